// File: rtl/ac97_command_sequencer.sv
// ac97_command_sequencer
//   Waits for the AC97 codec-ready indication, replays a fixed register
//   initialization table into ac97_controller's command slot, then turns
//   user volume/mute requests into master + headphone volume writes.
//   Optional feature macro: AC97_SEQ_MUTE_EN (enables the mute_toggle input).
module ac97_command_sequencer #(
  parameter int unsigned READY_TIMEOUT = 4000000,
  parameter logic [4:0]  VOL_DEFAULT   = 5'd8
) (
  input  logic        system_clock,
  input  logic        system_reset_b,
  input  logic        codec_ready,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        mute_toggle,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        init_done,
  output logic        timeout_err,
  output logic [4:0]  volume
);

  typedef enum logic [2:0] {
    WAIT_READY,
    INIT_ISSUE,
    RUN_IDLE,
    RUN_ISSUE,
    GAP,
    ERROR
  } state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  localparam int unsigned      CNT_W    = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READY_TIMEOUT - 1);

  localparam logic [7:0] ADDR_MASTER = 8'h02;
  localparam logic [7:0] ADDR_HPHONE = 8'h04;

  state_t           state, state_d;
  logic [CNT_W-1:0] ready_count, ready_count_d;
  logic [1:0]       init_idx, init_idx_d;
  logic             burst_second, burst_second_d;
  logic [15:0]      burst_mvol, burst_mvol_d;
  logic             drop, drop_d;
  logic             mute, mute_d;
  logic             pending, pending_d;
  logic [4:0]       volume_d;
  logic             init_done_d, timeout_err_d;
  logic [7:0]       cmd_addr_d;
  logic [15:0]      cmd_data_d;
  logic             changed, take_pending, start_burst, restart;
  logic [15:0]      mvol;
  cmd_t             entry;

  // Fixed initialization table; volume entries carry the value live at issue time.
  function automatic cmd_t init_entry(input logic [1:0] idx, input logic [15:0] mv);
    cmd_t c;
    case (idx)
      2'd0:    c = '{addr: ADDR_MASTER, data: mv};
      2'd1:    c = '{addr: ADDR_HPHONE, data: mv};
      2'd2:    c = '{addr: 8'h06,       data: 16'h8000};
      default: c = '{addr: 8'h18,       data: 16'h0808};
    endcase
    return c;
  endfunction

  assign mvol      = {mute, 2'b00, volume, 3'b000, volume};
  assign cmd_valid = (state == INIT_ISSUE) || (state == RUN_ISSUE);
  assign entry     = init_entry(init_idx, mvol);

`ifndef AC97_SEQ_MUTE_EN
  logic unused_mute_toggle;
  assign unused_mute_toggle = mute_toggle;
`endif

  // User requests: saturating volume step, optional mute flip, change detection.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    volume_d = volume;
    mute_d   = mute;
    changed  = 1'b0;
    if (state != ERROR) begin
      if (vol_up && !vol_down && (volume != 5'd0)) begin
        volume_d = volume - 5'd1;
        changed  = 1'b1;
      end else if (vol_down && !vol_up && (volume != 5'd31)) begin
        volume_d = volume + 5'd1;
        changed  = 1'b1;
      end
`ifdef AC97_SEQ_MUTE_EN
      if (mute_toggle) begin
        mute_d  = ~mute;
        changed = 1'b1;
      end
`endif
    end
  end

  // Next-state and command-slot logic.
  always_comb begin
    state_d        = state;
    ready_count_d  = ready_count;
    init_idx_d     = init_idx;
    burst_second_d = burst_second;
    burst_mvol_d   = burst_mvol;
    drop_d         = drop;
    init_done_d    = init_done;
    timeout_err_d  = timeout_err;
    cmd_addr_d     = cmd_addr;
    cmd_data_d     = cmd_data;
    take_pending   = 1'b0;
    start_burst    = 1'b0;
    restart        = 1'b0;

    case (state)
      WAIT_READY: begin
        ready_count_d = ready_count + CNT_W'(1);
        if (codec_ready) begin
          // init_idx is always 0 here, so entry is table row 0.
          state_d    = INIT_ISSUE;
          cmd_addr_d = entry.addr;
          cmd_data_d = entry.data;
        end else if (ready_count == CNT_LAST) begin
          state_d       = ERROR;
          timeout_err_d = 1'b1;
        end
      end

      INIT_ISSUE, RUN_ISSUE: begin
        // A codec-ready drop is remembered; the in-flight command still completes.
        if (!codec_ready) drop_d = 1'b1;
        if (cmd_ready) begin
          if (drop || !codec_ready) begin
            restart = 1'b1;
          end else begin
            state_d = GAP;
            if (state == INIT_ISSUE) begin
              if (init_idx == 2'd3) init_done_d = 1'b1;
              init_idx_d = init_idx + 2'd1;
            end else begin
              burst_second_d = ~burst_second;
            end
          end
        end
      end

      GAP: begin
        if (!codec_ready) begin
          restart = 1'b1;
        end else if (!init_done) begin
          state_d    = INIT_ISSUE;
          cmd_addr_d = entry.addr;
          cmd_data_d = entry.data;
        end else if (burst_second) begin
          state_d    = RUN_ISSUE;
          cmd_addr_d = ADDR_HPHONE;
          cmd_data_d = burst_mvol;
        end else if (pending) begin
          start_burst = 1'b1;
        end else begin
          state_d = RUN_IDLE;
        end
      end

      RUN_IDLE: begin
        if (!codec_ready)  restart     = 1'b1;
        else if (pending)  start_burst = 1'b1;
      end

      ERROR: ;

      default: restart = 1'b1;
    endcase

    if (start_burst) begin
      state_d      = RUN_ISSUE;
      burst_mvol_d = mvol;
      cmd_addr_d   = ADDR_MASTER;
      cmd_data_d   = mvol;
      take_pending = 1'b1;
    end

    if (restart) begin
      state_d        = WAIT_READY;
      ready_count_d  = '0;
      init_idx_d     = 2'd0;
      init_done_d    = 1'b0;
      burst_second_d = 1'b0;
      drop_d         = 1'b0;
    end

    // A change in the same cycle a burst starts survives as a new request.
    pending_d = (pending && !take_pending) || changed;
  end

  // State register.
  always_ff @(posedge system_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!system_reset_b) state <= WAIT_READY;
    else                 state <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge system_clock) begin
    // NOTE: every register is reset synchronously; there is no storage array to leave unreset.
    if (!system_reset_b) begin
      ready_count  <= '0;
      init_idx     <= 2'd0;
      burst_second <= 1'b0;
      burst_mvol   <= '0;
      drop         <= 1'b0;
      mute         <= 1'b0;
      pending      <= 1'b0;
      volume       <= VOL_DEFAULT;
      init_done    <= 1'b0;
      timeout_err  <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
    end else begin
      ready_count  <= ready_count_d;
      init_idx     <= init_idx_d;
      burst_second <= burst_second_d;
      burst_mvol   <= burst_mvol_d;
      drop         <= drop_d;
      mute         <= mute_d;
      pending      <= pending_d;
      volume       <= volume_d;
      init_done    <= init_done_d;
      timeout_err  <= timeout_err_d;
      cmd_addr     <= cmd_addr_d;
      cmd_data     <= cmd_data_d;
    end
  end

endmodule

// File: tb/tb_ac97_command_sequencer.sv
// Bench for ac97_command_sequencer: a scoreboard of expected command-slot
// transfers filled by the stimulus and drained by an independent monitor,
// plus a second instance with a short ready timeout.
`timescale 1ns/1ps
module tb_ac97_command_sequencer;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } xfer_t;

  logic system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  // Main instance
  logic        system_reset_b, codec_ready, vol_up, vol_down, mute_toggle, cmd_ready;
  logic        cmd_valid, init_done, timeout_err;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [4:0]  volume;

  // Short-timeout instance
  logic        to_reset_b;
  logic        to_zero = 1'b0;
  logic        to_one  = 1'b1;
  logic        to_cmd_valid, to_init_done, to_timeout_err;
  logic [7:0]  to_cmd_addr;
  logic [15:0] to_cmd_data;
  logic [4:0]  to_volume;
  logic        to_done = 1'b0;
  logic        to_seen_valid = 1'b0;

  int    checks = 0;
  int    errors = 0;
  int    xfers = 0;
  int    exp_xfers = 0;
  xfer_t sb[$];

  logic  gap_due = 1'b0;
  logic  stalled = 1'b0;
  xfer_t held;
  xfer_t exp_x;

  ac97_command_sequencer dut (
    .system_clock   (system_clock),
    .system_reset_b (system_reset_b),
    .codec_ready    (codec_ready),
    .vol_up         (vol_up),
    .vol_down       (vol_down),
    .mute_toggle    (mute_toggle),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .init_done      (init_done),
    .timeout_err    (timeout_err),
    .volume         (volume)
  );

  ac97_command_sequencer #(.READY_TIMEOUT(50)) dut_to (
    .system_clock   (system_clock),
    .system_reset_b (to_reset_b),
    .codec_ready    (to_zero),
    .vol_up         (to_zero),
    .vol_down       (to_zero),
    .mute_toggle    (to_zero),
    .cmd_valid      (to_cmd_valid),
    .cmd_ready      (to_one),
    .cmd_addr       (to_cmd_addr),
    .cmd_data       (to_cmd_data),
    .init_done      (to_init_done),
    .timeout_err    (to_timeout_err),
    .volume         (to_volume)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d);
    sb.push_back('{addr: a, data: d});
    exp_xfers++;
  endtask

  task automatic push_table(input logic [15:0] mv);
    push(8'h02, mv);
    push(8'h04, mv);
    push(8'h06, 16'h8000);
    push(8'h18, 16'h0808);
  endtask

  task automatic push_burst(input logic [15:0] mv);
    push(8'h02, mv);
    push(8'h04, mv);
  endtask

  task automatic pulse(input logic up, input logic dn, input logic mt);
    vol_up      = up;
    vol_down    = dn;
    mute_toggle = mt;
    tick();
    vol_up      = 1'b0;
    vol_down    = 1'b0;
    mute_toggle = 1'b0;
  endtask

  task automatic wait_init_done(input string name, input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(init_done), 32'd1);
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: scoreboard compare on each transfer, gap and stall-stability checks.
  initial begin
    forever begin
      @(negedge system_clock);
      if (!system_reset_b) begin
        gap_due = 1'b0;
        stalled = 1'b0;
      end else begin
        if (gap_due) check("gap_after_xfer", 32'(cmd_valid), 32'd0);
        gap_due = 1'b0;
        if (stalled && cmd_valid) check("stall_stable", 32'({cmd_addr, cmd_data}), 32'(held));
        stalled = cmd_valid && !cmd_ready;
        held    = '{addr: cmd_addr, data: cmd_data};
        if (cmd_valid && cmd_ready) begin
          xfers++;
          gap_due = 1'b1;
          check("xfer_was_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_x = sb.pop_front();
            check($sformatf("xfer%0d_addr_data", xfers), 32'({cmd_addr, cmd_data}), 32'(exp_x));
          end
        end
      end
    end
  end

  // Short-timeout instance: codec_ready never arrives.
  initial begin
    to_reset_b = 1'b0;
    repeat (3) tick();
    to_reset_b = 1'b1;
    for (int k = 0; k < 49; k++) begin
      tick();
      to_seen_valid = to_seen_valid | to_cmd_valid;
    end
    check("timeout_not_before_50", 32'(to_timeout_err), 32'd0);
    tick();
    check("timeout_at_50", 32'(to_timeout_err), 32'd1);
    repeat (30) begin
      tick();
      to_seen_valid = to_seen_valid | to_cmd_valid;
    end
    check("timeout_sticky", 32'(to_timeout_err), 32'd1);
    check("timeout_never_valid", 32'(to_seen_valid), 32'd0);
    to_done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int n;
    system_reset_b = 1'b0;
    codec_ready    = 1'b0;
    cmd_ready      = 1'b1;
    vol_up         = 1'b0;
    vol_down       = 1'b0;
    mute_toggle    = 1'b0;
    repeat (3) tick();
    check("rst_cmd_valid",   32'(cmd_valid),   32'd0);
    check("rst_cmd_addr",    32'(cmd_addr),    32'd0);
    check("rst_cmd_data",    32'(cmd_data),    32'd0);
    check("rst_init_done",   32'(init_done),   32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_volume",      32'(volume),      32'd8);

    // Init table after 100 cycles of waiting
    system_reset_b = 1'b1;
    repeat (100) tick();
    check("no_cmd_before_ready", 32'(cmd_valid), 32'd0);
    push_table(16'h0808);
    codec_ready = 1'b1;
    tick();
    check("ready_to_valid_latency", 32'(cmd_valid), 32'd1);
    wait_init_done("init_done_after_table", 50);
    check("init_xfer_count", 32'(xfers), 32'd4);
    repeat (5) tick();

    // Stalled handshake during a volume burst
    cmd_ready = 1'b0;
    push_burst(16'h0909);
    pulse(1'b0, 1'b1, 1'b0);
    check("vol_down_step", 32'(volume), 32'd9);
    repeat (10) tick();
    check("stall_presents_master", 32'({cmd_valid, cmd_addr}), 32'({1'b1, 8'h02}));
    cmd_ready = 1'b1;
    wait_sb_empty("stall_burst_drained", 20);
    repeat (5) tick();

    // Three vol_down during one burst coalesce into one follow-up
    cmd_ready = 1'b0;
    push_burst(16'h0808);
    push_burst(16'h0B0B);
    pulse(1'b1, 1'b0, 1'b0);
    check("vol_up_step", 32'(volume), 32'd8);
    repeat (2) tick();
    repeat (3) begin
      pulse(1'b0, 1'b1, 1'b0);
      tick();
    end
    check("coalesce_volume", 32'(volume), 32'd11);
    cmd_ready = 1'b1;
    wait_sb_empty("coalesce_drained", 30);
    repeat (20) tick();
    check("coalesce_no_extra", 32'(xfers), 32'(exp_xfers));

    // Walk to volume 0, then saturated and simultaneous requests
    cmd_ready = 1'b0;
    push_burst(16'h0A0A);
    push_burst(16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    check("walk_first_step", 32'(volume), 32'd10);
    tick();
    repeat (10) begin
      pulse(1'b1, 1'b0, 1'b0);
      tick();
    end
    check("walk_volume_zero", 32'(volume), 32'd0);
    cmd_ready = 1'b1;
    wait_sb_empty("walk_drained", 30);
    repeat (5) tick();
    pulse(1'b1, 1'b0, 1'b0);
    check("sat_zero_volume", 32'(volume), 32'd0);
    repeat (20) tick();
    check("sat_zero_no_burst", 32'(xfers), 32'(exp_xfers));
    push_burst(16'h0101);
    pulse(1'b0, 1'b1, 1'b0);
    wait_sb_empty("vol1_drained", 20);
    repeat (5) tick();
    pulse(1'b1, 1'b1, 1'b0);
    check("both_pulsed_volume", 32'(volume), 32'd1);
    repeat (20) tick();
    check("both_pulsed_no_burst", 32'(xfers), 32'(exp_xfers));

    // Reset in the middle of a stalled handshake
    cmd_ready = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check("pre_reset_valid", 32'(cmd_valid), 32'd1);
    system_reset_b = 1'b0;
    tick();
    check("reset_drops_valid", 32'(cmd_valid), 32'd0);
    check("reset_volume", 32'(volume), 32'd8);
    check("reset_cmd_data", 32'(cmd_data), 32'd0);
    check("reset_init_done", 32'(init_done), 32'd0);
    cmd_ready = 1'b1;
    push_table(16'h0808);
    system_reset_b = 1'b1;
    wait_init_done("reinit_done", 50);
    repeat (5) tick();

`ifdef AC97_SEQ_MUTE_EN
    // Mute burst with codec_ready dropped while the first write is in flight
    cmd_ready = 1'b0;
    push(8'h02, 16'h8808);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check("mute_burst_presented", 32'({cmd_valid, cmd_addr, cmd_data}), 32'({1'b1, 8'h02, 16'h8808}));
    codec_ready = 1'b0;
    repeat (2) tick();
    cmd_ready = 1'b1;
    wait_sb_empty("drop_inflight_completes", 20);
    tick();
    tick();
    check("drop_init_done_cleared", 32'(init_done), 32'd0);
    check("drop_no_cmd", 32'(cmd_valid), 32'd0);
    push_table(16'h8808);
    codec_ready = 1'b1;
    wait_init_done("replay_init_done", 50);
    repeat (20) tick();
    check("replay_no_extra", 32'(xfers), 32'(exp_xfers));
`else
    // mute_toggle has no effect in this build
    pulse(1'b0, 1'b0, 1'b1);
    check("mute_ignored_volume", 32'(volume), 32'd8);
    repeat (20) tick();
    check("mute_ignored_no_burst", 32'(xfers), 32'(exp_xfers));
    check("mute_ignored_idle", 32'(cmd_valid), 32'd0);
`endif

    n = 0;
    while (!to_done && n < 500) begin
      tick();
      n++;
    end
    check("timeout_bench_done", 32'(to_done), 32'd1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("total_xfers", 32'(xfers), 32'(exp_xfers));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
